// File: rtl/tdm_demux4_if.sv
// Bundle between the serial link front end and the TDM receive channel.
// The sender drives en/din/frame; the receiver returns the recovered frame and status.
interface tdm_demux4_if #(
    parameter int CH = 4,
    parameter int W  = 8
);
    localparam int SW = $clog2(CH);

    logic              en;
    logic              din;
    logic              frame;
    logic [CH*W-1:0]   dout;
    logic              frame_vld;
    logic [SW-1:0]     sel;
    logic              locked;
    logic              sync_err;

    modport master (
        output en, din, frame,
        input  dout, frame_vld, sel, locked, sync_err
    );

    modport slave (
        input  en, din, frame,
        output dout, frame_vld, sel, locked, sync_err
    );
endinterface

// File: rtl/tdm_demux4.sv
// Receive side of the CH-slot TDM link: shifts in MSB-first slots, stages them and
// publishes a whole frame at once; framing violations re-align or drop back to hunting.

module tdm_demux4_chk #(
    parameter int SW = 2
) (
    input logic          clk,
    input logic          rst_n,
    input logic          frame_vld,
    input logic          sync_err,
    input logic          locked,
    input logic [SW-1:0] sel
);
    a_pulse_excl: assert property (@(posedge clk) disable iff (!rst_n)
        !(frame_vld && sync_err));

    a_hunt_sel: assert property (@(posedge clk) disable iff (!rst_n)
        !locked |-> (sel == {SW{1'b0}}));
endmodule

module tdm_demux4 #(
    parameter int CH = 4,
    parameter int W  = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    tdm_demux4_if.slave  bus
);
    localparam int SW = $clog2(CH);
    localparam int CW = $clog2(W);

    localparam logic [0:0] ST_HUNT = 1'b0;
    localparam logic [0:0] ST_RECV = 1'b1;

    logic [0:0]             r_state;
    logic [CW-1:0]          r_bit_cnt;
    logic [SW-1:0]          r_sel;
    logic [W-2:0]           r_shift;
    logic [CH-1:0][W-1:0]   r_stage;
    logic [CH*W-1:0]        r_dout;
    logic                   r_frame_vld;
    logic                   r_sync_err;
    logic                   r_cmpl_pend;
    logic                   r_err_pend;
    logic                   r_locked;

    logic [0:0]             w_state_nx;
    logic [CW-1:0]          w_cnt_nx;
    logic [SW-1:0]          w_sel_nx;
    logic [W-2:0]           w_shift_nx;
    logic                   w_stage_we;
    logic                   w_cmpl;
    logic                   w_err;
    logic [W-1:0]           w_word;
    logic                   w_at_start;
    logic                   w_last_bit;

    function automatic logic [SW-1:0] next_sel(input logic [SW-1:0] s);
        if (s == SW'(CH - 1)) begin
            return {SW{1'b0}};
        end else begin
            return s + SW'(1);
        end
    endfunction

    assign w_word     = {r_shift, bus.din};
    assign w_at_start = (r_bit_cnt == {CW{1'b0}}) && (r_sel == {SW{1'b0}});
    assign w_last_bit = (r_bit_cnt == CW'(W - 1));

    // Next-state decode for one qualified bit: hunt, shift, slot close, framing checks.
    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_bit_cnt;
        w_sel_nx   = r_sel;
        w_shift_nx = r_shift;
        w_stage_we = 1'b0;
        w_cmpl     = 1'b0;
        w_err      = 1'b0;
        if (bus.en) begin
            case (r_state)
                ST_HUNT: begin
                    if (bus.frame) begin
                        w_state_nx = ST_RECV;
                        w_shift_nx = (W-1)'(bus.din);
                        w_cnt_nx   = CW'(1);
                        w_sel_nx   = {SW{1'b0}};
                    end else begin
                        w_state_nx = ST_HUNT;
                    end
                end
                ST_RECV: begin
                    if (bus.frame) begin
                        // A strobe off the slot-0 boundary restarts the frame on this bit.
                        w_err      = !w_at_start;
                        w_shift_nx = (W-1)'(bus.din);
                        w_cnt_nx   = CW'(1);
                        w_sel_nx   = {SW{1'b0}};
                    end else if (w_at_start) begin
                        w_err      = 1'b1;
                        w_state_nx = ST_HUNT;
                        w_cnt_nx   = {CW{1'b0}};
                        w_sel_nx   = {SW{1'b0}};
                        w_shift_nx = {(W-1){1'b0}};
                    end else begin
                        w_shift_nx = w_word[W-2:0];
                        if (w_last_bit) begin
                            w_stage_we = 1'b1;
                            w_cnt_nx   = {CW{1'b0}};
                            w_sel_nx   = next_sel(r_sel);
                            w_cmpl     = (r_sel == SW'(CH - 1));
                        end else begin
                            w_cnt_nx   = r_bit_cnt + CW'(1);
                        end
                    end
                end
                default: begin
                    w_state_nx = ST_HUNT;
                    w_cnt_nx   = {CW{1'b0}};
                    w_sel_nx   = {SW{1'b0}};
                end
            endcase
        end else begin
            w_state_nx = r_state;
        end
    end

    // Receive-path state: FSM, bit/slot counters, shift register and slot staging.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_HUNT;
            r_bit_cnt <= {CW{1'b0}};
            r_sel     <= {SW{1'b0}};
            r_shift   <= {(W-1){1'b0}};
            r_stage   <= {(CH*W){1'b0}};
            r_locked  <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_bit_cnt <= w_cnt_nx;
            r_sel     <= w_sel_nx;
            r_shift   <= w_shift_nx;
            r_locked  <= (w_state_nx == ST_RECV);
            if (w_stage_we) begin
                r_stage[r_sel] <= w_word;
            end else begin
                r_stage <= r_stage;
            end
        end
    end

    // Publication stage: the frame and both pulses appear one cycle after the deciding bit,
    // so a completion and an error on the following bit land on different edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cmpl_pend <= 1'b0;
            r_err_pend  <= 1'b0;
            r_frame_vld <= 1'b0;
            r_sync_err  <= 1'b0;
            r_dout      <= {(CH*W){1'b0}};
        end else begin
            r_cmpl_pend <= w_cmpl;
            r_err_pend  <= w_err;
            r_frame_vld <= r_cmpl_pend;
            r_sync_err  <= r_err_pend;
            if (r_cmpl_pend) begin
                r_dout <= r_stage;
            end else begin
                r_dout <= r_dout;
            end
        end
    end

    assign bus.dout      = r_dout;
    assign bus.frame_vld = r_frame_vld;
    assign bus.sel       = r_sel;
    assign bus.locked    = r_locked;
    assign bus.sync_err  = r_sync_err;

    tdm_demux4_chk #(.SW(SW)) u_chk (
        .clk       (clk),
        .rst_n     (rst_n),
        .frame_vld (r_frame_vld),
        .sync_err  (r_sync_err),
        .locked    (r_locked),
        .sel       (r_sel)
    );
endmodule

// File: tb/tb_tdm_demux4.sv
// Directed bench for tdm_demux4: a frame-position model predicts every output each cycle,
// and literal expectations pin the recovered words, pulse counts and pulse spacing.
module tb_tdm_demux4;
    localparam int CH = 4;
    localparam int W  = 8;
    localparam int NB = CH * W;

    logic clk;
    logic rst_n;

    tdm_demux4_if #(.CH(CH), .W(W)) bus();

    tdm_demux4 #(.CH(CH), .W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Model: position of the next bit within the frame plus the bits collected so far.
    bit              m_locked;
    int              m_pos;
    bit              m_bits [NB];
    bit              m_pend_vld;
    bit              m_pend_err;
    logic [NB-1:0]   m_pend_dout;
    logic [NB-1:0]   e_dout;
    bit              e_vld;
    bit              e_err;
    bit              e_locked;
    int              e_sel;

    int n_cmp;
    int n_bad;
    int cyc;
    int vld_q[$];
    int err_q[$];
    logic [NB-1:0] got_q[$];

    task automatic chk(input string name, input logic [NB-1:0] act, input logic [NB-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic reset_model();
        m_locked = 1'b0; m_pos = 0; m_pend_vld = 1'b0; m_pend_err = 1'b0;
        m_pend_dout = '0; e_dout = '0; e_vld = 1'b0; e_err = 1'b0;
        e_locked = 1'b0; e_sel = 0;
        for (int i = 0; i < NB; i++) m_bits[i] = 1'b0;
    endtask

    task automatic model_edge(input logic en, input logic din, input logic frame);
        e_vld = m_pend_vld;
        e_err = m_pend_err;
        if (m_pend_vld) e_dout = m_pend_dout;
        m_pend_vld = 1'b0;
        m_pend_err = 1'b0;
        if (en) begin
            if (!m_locked) begin
                if (frame) begin
                    m_locked = 1'b1; m_bits[0] = din; m_pos = 1;
                end
            end else if (frame) begin
                m_pend_err = (m_pos != 0);
                m_bits[0] = din; m_pos = 1;
            end else if (m_pos == 0) begin
                m_pend_err = 1'b1;
                m_locked = 1'b0;
            end else begin
                m_bits[m_pos] = din;
                if (m_pos == NB - 1) begin
                    m_pend_vld = 1'b1;
                    for (int k = 0; k < CH; k++)
                        for (int j = 0; j < W; j++)
                            m_pend_dout[k*W + W-1-j] = m_bits[k*W + j];
                    m_pos = 0;
                end else begin
                    m_pos = m_pos + 1;
                end
            end
        end
        e_locked = m_locked;
        e_sel = m_locked ? (m_pos / W) : 0;
    endtask

    task automatic check_outputs();
        chk("dout",      bus.dout,           e_dout);
        chk("frame_vld", NB'(bus.frame_vld), NB'(e_vld));
        chk("sync_err",  NB'(bus.sync_err),  NB'(e_err));
        chk("locked",    NB'(bus.locked),    NB'(e_locked));
        chk("sel",       NB'(bus.sel),       NB'(e_sel));
        if (bus.frame_vld === 1'b1) begin
            vld_q.push_back(cyc);
            got_q.push_back(bus.dout);
        end
        if (bus.sync_err === 1'b1) err_q.push_back(cyc);
    endtask

    task automatic step(input logic en, input logic din, input logic frame);
        bus.en = en; bus.din = din; bus.frame = frame;
        @(posedge clk);
        cyc++;
        model_edge(en, din, frame);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic send_bits(input logic [NB-1:0] data, input int nbits, input int gap, input bit strobe);
        for (int i = 0; i < nbits; i++) begin
            automatic int k = i / W;
            automatic int j = i % W;
            automatic logic b = data[k*W + W-1-j];
            step(1'b1, b, strobe && (i == 0));
            for (int g = 0; g < gap; g++) step(1'b0, 1'($urandom), 1'($urandom));
        end
    endtask

    task automatic clear_log();
        vld_q.delete(); err_q.delete(); got_q.delete();
    endtask

    task automatic apply_reset(input string tag);
        rst_n = 1'b0;
        #1;
        chk({tag, "_dout"},   bus.dout,           {NB{1'b0}});
        chk({tag, "_locked"}, NB'(bus.locked),    {NB{1'b0}});
        chk({tag, "_sel"},    NB'(bus.sel),       {NB{1'b0}});
        chk({tag, "_vld"},    NB'(bus.frame_vld), {NB{1'b0}});
        reset_model();
        @(negedge clk);
        check_outputs();
        rst_n = 1'b1;
    endtask

    initial begin
        n_cmp = 0; n_bad = 0; cyc = 0;
        rst_n = 1'b1;
        bus.en = 1'b0; bus.din = 1'b0; bus.frame = 1'b0;
        reset_model();
        #2;
        apply_reset("rst0");

        // One frame, continuous en.
        clear_log();
        send_bits(32'hF00F3CA5, 32, 0, 1'b1);
        chk("t2_vld_not_yet", NB'(bus.frame_vld), {NB{1'b0}});
        step(1'b0, 1'b0, 1'b0);
        chk("t2_vld",    NB'(bus.frame_vld), NB'(1'b1));
        chk("t2_dout",   bus.dout,           32'hF00F3CA5);
        chk("t2_err",    NB'(bus.sync_err),  {NB{1'b0}});
        step(1'b0, 1'b0, 1'b0);
        chk("t2_vld_one_cycle", NB'(bus.frame_vld), {NB{1'b0}});

        // Reset mid-stream loses the partial frame and the published word.
        send_bits(32'h12345678, 13, 0, 1'b1);
        apply_reset("rst_mid");

        // Same frame with en only every third cycle.
        clear_log();
        send_bits(32'hF00F3CA5, 32, 2, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        chk("t3_dout",  bus.dout,           32'hF00F3CA5);
        chk("t3_nvld",  NB'(vld_q.size()),  NB'(1));
        chk("t3_nerr",  NB'(err_q.size()),  NB'(0));

        // Back-to-back frames.
        clear_log();
        send_bits(32'h44332211, 32, 0, 1'b1);
        send_bits(32'hDDCCBBAA, 32, 0, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        chk("t4_nvld",    NB'(vld_q.size()), NB'(2));
        if (got_q.size() >= 2) begin
            chk("t4_first",   got_q[0], 32'h44332211);
            chk("t4_second",  got_q[1], 32'hDDCCBBAA);
            chk("t4_spacing", NB'(vld_q[1] - vld_q[0]), NB'(32));
        end else begin
            chk("t4_have_two", NB'(got_q.size()), NB'(2));
        end

        // Early strobe at bit 5 of slot 2 re-aligns without losing lock.
        clear_log();
        send_bits(32'h87654321, 2*W + 5, 0, 1'b1);
        send_bits(32'h0BADF00D, 32, 0, 1'b1);
        chk("t5_locked", NB'(bus.locked), NB'(1'b1));
        step(1'b0, 1'b0, 1'b0);
        chk("t5_nerr",  NB'(err_q.size()), NB'(1));
        chk("t5_nvld",  NB'(vld_q.size()), NB'(1));
        chk("t5_dout",  bus.dout,          32'h0BADF00D);

        // Good frame, then the next frame's strobe is missing.
        clear_log();
        send_bits(32'hC3C3A5A5, 32, 0, 1'b1);
        send_bits(32'h13579BDF, 32, 0, 1'b0);
        chk("t6_locked",  NB'(bus.locked), {NB{1'b0}});
        chk("t6_keep",    bus.dout,        32'hC3C3A5A5);
        chk("t6_nerr",    NB'(err_q.size()), NB'(1));
        if ((err_q.size() == 1) && (vld_q.size() == 1)) begin
            chk("t6_edges", NB'(err_q[0] - vld_q[0]), NB'(1));
        end else begin
            chk("t6_nvld", NB'(vld_q.size()), NB'(1));
        end
        send_bits(32'h5A5A0FF0, 32, 0, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        chk("t6_relock_dout", bus.dout, 32'h5A5A0FF0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
